// File: rtl/replay_unit.sv
// replay_unit: copies GPR state and PC from a healthy core into a faulty core
// during error recovery, with protocol checking of the controller handshake.
module replay_unit #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  halt_i,
    input  logic                  shift_i,
    input  logic                  resume_i,
    input  logic [ADDR_WIDTH-1:0] replay_addr_i,
    output logic [ADDR_WIDTH-1:0] src_raddr_o,
    input  logic [DATA_WIDTH-1:0] src_rdata_i,
    input  logic [DATA_WIDTH-1:0] src_pc_i,
    output logic                  dst_we_o,
    output logic [ADDR_WIDTH-1:0] dst_waddr_o,
    output logic [DATA_WIDTH-1:0] dst_wdata_o,
    output logic                  dst_pc_we_o,
    output logic [DATA_WIDTH-1:0] dst_pc_o,
    output logic                  core_halt_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  proto_err_o
);
    typedef enum logic [1:0] {IDLE, HALTED, COPY, RESUME} state_e;

    localparam logic [ADDR_WIDTH:0] CNT_MAX = {1'b0, {ADDR_WIDTH{1'b1}}};

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] last_q, last_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic                  we_q, we_d;
    logic                  pc_we_q, pc_we_d;
    logic                  err_q, err_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            last_q  <= '0;
            cnt_q   <= '0;
            waddr_q <= '0;
            pc_q    <= '0;
            we_q    <= 1'b0;
            pc_we_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            waddr_q <= waddr_d;
            pc_q    <= pc_d;
            we_q    <= we_d;
            pc_we_q <= pc_we_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        waddr_d = replay_addr_i;
        pc_d    = pc_q;
        we_d    = 1'b0;
        pc_we_d = 1'b0;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (halt_i) begin
                    state_d = HALTED;
                    err_d   = 1'b0;
                end
            end
            HALTED: begin
                if (halt_i) err_d = 1'b1;
                if (resume_i) begin
                    err_d   = 1'b1;
                    state_d = RESUME;
                end else if (shift_i && !halt_i) begin
                    pc_d    = src_pc_i;
                    pc_we_d = 1'b1;
                    last_d  = '0;
                    cnt_d   = '0;
                    state_d = COPY;
                end
            end
            COPY: begin
                if (halt_i) err_d = 1'b1;
                if (resume_i) begin
                    state_d = RESUME;
                    if (cnt_q < CNT_MAX) err_d = 1'b1;
                end else if (!shift_i && replay_addr_i != last_q) begin
                    // register 0 is hardwired zero: tracked as last address but never written
                    last_d = replay_addr_i;
                    if (replay_addr_i != '0) begin
                        we_d  = 1'b1;
                        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                    end
                end
            end
            RESUME: state_d = IDLE;
        endcase
    end

    assign src_raddr_o = replay_addr_i;
    assign dst_we_o    = we_q;
    assign dst_waddr_o = we_q ? waddr_q : '0;
    assign dst_wdata_o = we_q ? src_rdata_i : '0;
    assign dst_pc_we_o = pc_we_q;
    assign dst_pc_o    = pc_q;
    assign core_halt_o = (state_q == HALTED) || (state_q == COPY);
    assign busy_o      = state_q != IDLE;
    assign done_o      = state_q == RESUME;
    assign proto_err_o = err_q;
endmodule
